multiplier_unit: RTL and testbench

Iterative shift-add integer multiplier; the inverse-operation companion to the divider unit in the CPU execute stage. Serves MULT/MULTU by producing a full 2×DATA_WIDTH product split into HI/LO halves. Accepts one operation per start pulse, computes it over DATA_WIDTH cycles, and pulses `done_signal` when the product registers are valid. Results hold until the next operation completes.

---
 rtl/multiplier_unit_pkg.sv | 15 +
 rtl/multiplier_unit_twos_negate.sv | 13 +
 rtl/multiplier_unit.sv | 123 ++++++++++++
 tb/tb_multiplier_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM states and
// default sizing.
package multiplier_unit_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int ITER_COUNT_WIDTH   = $clog2(DEFAULT_DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CALC     = 2'd1,
        ST_SIGN_FIX = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/multiplier_unit_twos_negate.sv
// Conditional two's-complement negation; passes the value through unchanged
// when i_negate is low. Negating zero yields zero.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_negate,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/multiplier_unit.sv
// Iterative shift-add multiplier producing a 2*DATA_WIDTH product (HI/LO)
// for MULT/MULTU, one result bit-step per cycle.
module multiplier_unit
    import multiplier_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock_signal,
    input  logic                  reset_signal,
    input  logic                  start_signal,
    input  logic                  signed_multiply,
    input  logic [DATA_WIDTH-1:0] multiplicand_input,
    input  logic [DATA_WIDTH-1:0] multiplier_input,
    output logic                  busy_signal,
    output logic                  done_signal,
    output logic [DATA_WIDTH-1:0] product_high_output,
    output logic [DATA_WIDTH-1:0] product_low_output,
    output logic [1:0]            debug_state
);

    // Handshake: start_signal is accepted only while idle (busy low, done low);
    // busy_signal covers CALC and SIGN_FIX; done_signal is a one-cycle pulse
    // marking fresh HI/LO; starts seen while busy or done are dropped, not queued.

    localparam int                 CW        = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]      LAST_ITER = CW'(DATA_WIDTH - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [DATA_WIDTH-1:0]     r_multiplicand;
    logic [DATA_WIDTH-1:0]     r_multiplier;
    logic [2*DATA_WIDTH-1:0]   r_accum;
    logic [CW-1:0]             r_count;
    logic                      r_negate;
    logic [DATA_WIDTH-1:0]     r_product_high;
    logic [DATA_WIDTH-1:0]     r_product_low;

    logic [DATA_WIDTH-1:0]     w_mag_a;
    logic [DATA_WIDTH-1:0]     w_mag_b;
    logic [DATA_WIDTH-1:0]     w_addend;
    logic [DATA_WIDTH:0]       w_sum;
    logic [2*DATA_WIDTH-1:0]   w_fixed;
    logic                      w_neg_a;
    logic                      w_neg_b;

    assign w_neg_a = signed_multiply & multiplicand_input[DATA_WIDTH-1];
    assign w_neg_b = signed_multiply & multiplier_input[DATA_WIDTH-1];

    twos_negate #(.WIDTH(DATA_WIDTH)) u_mag_a (
        .i_negate (w_neg_a),
        .i_value  (multiplicand_input),
        .o_value  (w_mag_a)
    );

    twos_negate #(.WIDTH(DATA_WIDTH)) u_mag_b (
        .i_negate (w_neg_b),
        .i_value  (multiplier_input),
        .o_value  (w_mag_b)
    );

    twos_negate #(.WIDTH(2*DATA_WIDTH)) u_fix (
        .i_negate (r_negate),
        .i_value  (r_accum),
        .o_value  (w_fixed)
    );

    // The carry out of the upper-half add becomes the new accumulator MSB.
    assign w_addend = r_multiplier[0] ? r_multiplicand : '0;
    assign w_sum    = {1'b0, r_accum[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, w_addend};

    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            r_state        <= ST_IDLE;
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_accum        <= '0;
            r_count        <= '0;
            r_negate       <= 1'b0;
            r_product_high <= '0;
            r_product_low  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start_signal) begin
                        r_multiplicand <= w_mag_a;
                        r_multiplier   <= w_mag_b;
                        r_negate       <= w_neg_a ^ w_neg_b;
                        r_accum        <= '0;
                        r_count        <= '0;
                    end
                end
                ST_CALC: begin
                    r_accum      <= {w_sum, r_accum[DATA_WIDTH-1:1]};
                    r_multiplier <= r_multiplier >> 1;
                    r_count      <= r_count + CW'(1);
                end
                ST_SIGN_FIX: begin
                    {r_product_high, r_product_low} <= w_fixed;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (start_signal) w_next_state = ST_CALC;
            ST_CALC:     if (r_count == LAST_ITER) w_next_state = ST_SIGN_FIX;
            ST_SIGN_FIX: w_next_state = ST_DONE;
            ST_DONE:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    assign busy_signal         = (r_state == ST_CALC) || (r_state == ST_SIGN_FIX);
    assign done_signal         = (r_state == ST_DONE);
    assign product_high_output = r_product_high;
    assign product_low_output  = r_product_low;
    assign debug_state         = r_state;

endmodule

// File: tb/tb_multiplier_unit.sv
// Self-checking bench for multiplier_unit: directed cases, protocol scenarios
// and random operands checked against an arithmetic reference model.
module tb_multiplier_unit;
  import multiplier_unit_pkg::*;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sgn;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [1:0]    dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  multiplier_unit #(.DATA_WIDTH(W)) dut (
    .clock_signal        (clk),
    .reset_signal        (rst),
    .start_signal        (start),
    .signed_multiply     (sgn),
    .multiplicand_input  (mcand),
    .multiplier_input    (mplier),
    .busy_signal         (busy),
    .done_signal         (done),
    .product_high_output (hi),
    .product_low_output  (lo),
    .debug_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: full-width product by plain integer arithmetic
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint sa;
    longint sb;
    logic [2*W-1:0] ua;
    logic [2*W-1:0] ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Runs one operation starting at the current negedge (DUT idle).
  // pulse_at: edge index at which a stray 2x2 start is presented (0 = none).
  // pulse_done: present a stray start in the done cycle too.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string name, input int pulse_at, input bit pulse_done);
    logic [2*W-1:0] prev;
    logic [2*W-1:0] exp_v;
    int lat;
    int busy_bad;
    bit changed;
    exp_q.push_back(model(a, b, s));
    prev  = {hi, lo};
    start = 1'b1; sgn = s; mcand = a; mplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; sgn = $urandom_range(0, 1); mcand = $urandom; mplier = $urandom;
    lat = 0; busy_bad = 0; changed = 1'b0;
    if (!busy) busy_bad++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_bad++;
      if ({hi, lo} !== prev) changed = 1'b1;
      if (pulse_at != 0 && n == pulse_at - 1) begin
        start = 1'b1; mcand = 32'd2; mplier = 32'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected 33", name, lat);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("FAIL %s busy: dropped in %0d cycles, expected 0", name, busy_bad);
    end
    n_checks++;
    if (changed) begin
      n_fail++;
      $display("FAIL %s hold: outputs changed before done, expected stable %h", name, prev);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if ({hi, lo} !== exp_v) begin
      n_fail++;
      $display("FAIL %s product: got %h_%h expected %h_%h", name, hi, lo,
               exp_v[2*W-1:W], exp_v[W-1:0]);
    end
    if (pulse_done) begin
      start = 1'b1; mcand = 32'd2; mplier = 32'd2;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; mcand = '0; mplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b st=%0d expected zeros/idle",
               hi, lo, busy, done, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "umax", 0, 1'b0);
    run_op(32'hFFFFFFFD, 32'd7,        1'b1, "neg3x7_s", 0, 1'b0);
    run_op(32'hFFFFFFFD, 32'd7,        1'b0, "neg3x7_u", 0, 1'b0);
    run_op(32'h80000000, 32'h80000000, 1'b1, "minxmin_s", 0, 1'b0);
    run_op(32'hFFFFFFFB, 32'd0,        1'b1, "neg5x0_s", 0, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_op(32'd6, 32'd7, 1'b0, "ignored_start", 10, 1'b1);
  endtask

  task automatic test_reset_mid();
    int stray;
    start = 1'b1; sgn = 1'b0; mcand = 32'd1000; mplier = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b expected all 0",
               hi, lo, busy, done);
    end
    stray = 0;
    repeat (36) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_discard: got %0d busy/done cycles expected 0", stray);
    end
    run_op(32'd9, 32'd9, 1'b0, "after_reset_9x9", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] first;
    run_op(32'd12345, 32'd678, 1'b0, "b2b_first", 0, 1'b0);
    first = 64'd12345 * 64'd678;
    n_checks++;
    if ({hi, lo} !== first) begin
      n_fail++;
      $display("FAIL b2b_hold_idle: got %h expected %h", {hi, lo}, first);
    end
    run_op(32'hFFFF0001, 32'h00012345, 1'b1, "b2b_second", 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = '0;
        2: a = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(a, b, 1'(($urandom_range(0, 1))), "random", 0, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
